// File: rtl/fx_switch_ctrl.sv
// Click-free effect selector: debounces a new effect request, fades the stereo
// output to silence, swaps the effect select while muted, then fades back up.
module fx_switch_ctrl #(
  parameter int WIDTH     = 16,
  parameter int DEBOUNCE  = 4,
  parameter int RAMP_STEP = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             sample_tick,
  input  logic [3:0]       sel_req,
  input  logic [WIDTH-1:0] leftin,
  input  logic [WIDTH-1:0] rightin,
  output logic [3:0]       sel_fx,
  output logic [WIDTH-1:0] leftout,
  output logic [WIDTH-1:0] rightout,
  output logic             busy
);

  localparam int CW = $clog2(DEBOUNCE + 1);
  localparam int PW = WIDTH + 10;
  localparam logic [8:0] STEP  = 9'(RAMP_STEP);
  localparam logic [8:0] LIMIT = 9'(256 - RAMP_STEP);
  localparam logic [8:0] UNITY = 9'd256;

  typedef enum logic [2:0] {
    IDLE,
    DEB,
    FADE_OUT,
    SWAP,
    FADE_IN
  } state_t;

  state_t                state;
  logic [8:0]            gain;
  logic [3:0]            cand;
  logic [CW-1:0]         cnt;
  logic                  legal;
  logic signed [PW-1:0]  lprod;
  logic signed [PW-1:0]  rprod;

  always_comb begin
    legal = 1'b0;
    case (sel_req)
      4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000: legal = 1'b1;
      default: legal = 1'b0;
    endcase
  end

  // Gain is zero-extended so the product stays signed; 256 is exact unity.
  always_comb begin
    lprod = PW'($signed(leftin))  * PW'($signed({1'b0, gain}));
    rprod = PW'($signed(rightin)) * PW'($signed({1'b0, gain}));
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      gain     <= UNITY;
      cand     <= '0;
      cnt      <= '0;
      sel_fx   <= '0;
      leftout  <= '0;
      rightout <= '0;
      busy     <= 1'b0;
    end else if (sample_tick) begin
      leftout  <= WIDTH'(lprod >>> 8);
      rightout <= WIDTH'(rprod >>> 8);
      unique case (state)
        IDLE: begin
          if (legal && sel_req != sel_fx) begin
            cand  <= sel_req;
            cnt   <= CW'(1);
            busy  <= 1'b1;
            state <= (DEBOUNCE == 1) ? FADE_OUT : DEB;
          end
        end
        DEB: begin
          if (!legal || sel_req == sel_fx) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (sel_req == cand) begin
            cnt <= cnt + CW'(1);
            if (cnt == CW'(DEBOUNCE - 1)) state <= FADE_OUT;
          end else begin
            cand <= sel_req;
            cnt  <= CW'(1);
          end
        end
        FADE_OUT: begin
          if (gain <= STEP) begin
            gain  <= '0;
            state <= SWAP;
          end else begin
            gain <= gain - STEP;
          end
        end
        SWAP: begin
          sel_fx <= cand;
          state  <= FADE_IN;
        end
        FADE_IN: begin
          if (gain >= LIMIT) begin
            gain  <= UNITY;
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            gain <= gain + STEP;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
